commit_progress_monitor: RTL and testbench

Synthesizable, parametrised commit-progress monitor for the core's retire stage. It counts cycles and committed instructions across a configurable number of commit lanes and detects commit stalls. It emits periodic progress reports over a valid/ready handshake. It sits beside the ROB in `sim_top`/FPGA builds and replaces the bench-only watchdog logic.

---
 rtl/commit_progress_monitor_if.sv | 36 +++
 rtl/commit_progress_monitor.sv | 129 ++++++++++++
 tb/tb_commit_progress_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/commit_progress_monitor_if.sv
// Commit-lane inputs and progress-report handshake of commit_progress_monitor.
// report_window is present only when COMMIT_MONITOR_WINDOW_EN is defined.
interface commit_progress_monitor_if #(
  parameter int COMMIT_WIDTH = 6,
  parameter int CNT_WIDTH    = 64
);
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic                    commit_is_walk;
  logic                    clear;
  logic                    stuck;
  logic                    stuck_pulse;
  logic                    report_valid;
  logic                    report_ready;
  logic [CNT_WIDTH-1:0]    report_cycles;
  logic [CNT_WIDTH-1:0]    report_instrs;
  logic                    report_overrun;
`ifdef COMMIT_MONITOR_WINDOW_EN
  logic [CNT_WIDTH-1:0]    report_window;
`endif

  modport master (
    input  commit_valid, commit_is_walk, clear, report_ready,
    output stuck, stuck_pulse, report_valid, report_cycles, report_instrs, report_overrun
`ifdef COMMIT_MONITOR_WINDOW_EN
    , output report_window
`endif
  );

  modport slave (
    output commit_valid, commit_is_walk, clear, report_ready,
    input  stuck, stuck_pulse, report_valid, report_cycles, report_instrs, report_overrun
`ifdef COMMIT_MONITOR_WINDOW_EN
    , input report_window
`endif
  );
endinterface

// File: rtl/commit_progress_monitor.sv
// Retire-stage progress monitor: cycle/instr counters, stall FSM, periodic reports on valid/ready.
// Reports are overwritten (with sticky overrun) if not accepted in time; COMMIT_MONITOR_WINDOW_EN adds report_window.
module commit_progress_monitor #(
  parameter int COMMIT_WIDTH    = 6,
  parameter int CNT_WIDTH       = 64,
  parameter int STUCK_LIMIT     = 5000,
  parameter int REPORT_INTERVAL = 10000
) (
  input logic                       clock,
  input logic                       reset,
  commit_progress_monitor_if.master mon
);
  localparam int TW = $clog2(STUCK_LIMIT + 2);
  localparam int IW = $clog2(REPORT_INTERVAL);
  localparam int PW = $clog2(COMMIT_WIDTH + 1);
  localparam logic [TW-1:0] LIMIT     = TW'(STUCK_LIMIT);
  localparam logic [TW-1:0] LIMIT_SAT = TW'(STUCK_LIMIT + 1);
  localparam logic [IW-1:0] INTV_LOAD = IW'(REPORT_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, STUCK} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        stuck_timer, stuck_timer_nxt;
  logic                 pulse_nxt, stuck_pulse_q;
  logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
  logic [IW-1:0]        intv;
  logic [PW-1:0]        lanes;
  logic                 has_commit, capture, xfer;
  logic                 rpt_valid, rpt_overrun;
  logic [CNT_WIDTH-1:0] rpt_cycles, rpt_instrs;

  assign has_commit = !mon.commit_is_walk && mon.commit_valid[0];
  assign capture    = (intv == '0);
  assign xfer       = rpt_valid && mon.report_ready;

  // Lanes count individually; gaps in commit_valid are legal.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) lanes = lanes + PW'(mon.commit_valid[i]);
  end

  always_comb begin
    state_nxt       = state;
    stuck_timer_nxt = stuck_timer;
    case (state)
      IDLE: begin
        stuck_timer_nxt = '0;
        if (has_commit) state_nxt = RUN;
      end
      RUN: begin
        if (has_commit) begin
          stuck_timer_nxt = '0;
        end else begin
          if (stuck_timer != LIMIT_SAT) stuck_timer_nxt = stuck_timer + 1'b1;
          if (stuck_timer == LIMIT) state_nxt = STUCK;
        end
      end
      STUCK: begin
        if (mon.clear) begin
          state_nxt       = RUN;
          stuck_timer_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pulse_nxt = (state_nxt == STUCK) && (state != STUCK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      stuck_timer   <= '0;
      stuck_pulse_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      stuck_timer   <= stuck_timer_nxt;
      stuck_pulse_q <= pulse_nxt;
    end
  end

  // Capture takes the value cycle_cnt will hold after this edge, but the pre-update instr_cnt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instr_cnt   <= '0;
      intv        <= INTV_LOAD;
      rpt_valid   <= 1'b0;
      rpt_overrun <= 1'b0;
      rpt_cycles  <= '0;
      rpt_instrs  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (!mon.commit_is_walk) instr_cnt <= instr_cnt + CNT_WIDTH'(lanes);
      intv <= capture ? INTV_LOAD : intv - 1'b1;
      if (capture) begin
        rpt_valid  <= 1'b1;
        rpt_cycles <= cycle_cnt + 1'b1;
        rpt_instrs <= instr_cnt;
      end else if (xfer) begin
        rpt_valid <= 1'b0;
      end
      if (mon.clear) rpt_overrun <= 1'b0;
      if (capture && rpt_valid && !mon.report_ready) rpt_overrun <= 1'b1;
    end
  end

`ifdef COMMIT_MONITOR_WINDOW_EN
  logic [CNT_WIDTH-1:0] last_cap_instrs, rpt_window;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_cap_instrs <= '0;
      rpt_window      <= '0;
    end else if (capture) begin
      rpt_window      <= instr_cnt - last_cap_instrs;
      last_cap_instrs <= instr_cnt;
    end
  end

  assign mon.report_window = rpt_window;
`endif

  assign mon.stuck          = (state == STUCK);
  assign mon.stuck_pulse    = stuck_pulse_q;
  assign mon.report_valid   = rpt_valid;
  assign mon.report_cycles  = rpt_cycles;
  assign mon.report_instrs  = rpt_instrs;
  assign mon.report_overrun = rpt_overrun;
endmodule

// File: tb/tb_commit_progress_monitor.sv
// Bench for commit_progress_monitor: directed scenarios plus random traffic against a behavioural model.
module tb_commit_progress_monitor;
  localparam int CW   = 6;
  localparam int CNTW = 16;
  localparam int LIM  = 4;
  localparam int RI   = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  commit_progress_monitor_if #(.COMMIT_WIDTH(CW), .CNT_WIDTH(CNTW)) mon ();

  commit_progress_monitor #(
    .COMMIT_WIDTH(CW), .CNT_WIDTH(CNTW), .STUCK_LIMIT(LIM), .REPORT_INTERVAL(RI)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (mon)
  );

  always #5 clock = ~clock;

  // Reference model: edges since reset, commit-free run length, report register.
  int unsigned     m_edges;
  int              m_idle;
  bit              m_started, m_stuck, m_pulse, m_rv, m_ov;
  logic [CNTW-1:0] m_instr, m_prev, m_rc, m_ri, m_win;

  task automatic model_reset();
    m_edges = 0; m_idle = 0; m_started = 0; m_stuck = 0; m_pulse = 0;
    m_rv = 0; m_ov = 0; m_instr = '0; m_prev = '0; m_rc = '0; m_ri = '0; m_win = '0;
  endtask

  task automatic model_edge();
    bit              has, cap;
    logic [CNTW-1:0] pre;
    has     = !mon.commit_is_walk && mon.commit_valid[0];
    m_pulse = 0;
    if (m_stuck) begin
      if (mon.clear) begin m_stuck = 0; m_idle = 0; end
    end else if (!m_started) begin
      if (has) m_started = 1;
    end else if (has) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == LIM + 1) begin m_stuck = 1; m_pulse = 1; end
    end
    m_edges++;
    pre = m_instr;
    cap = (m_edges % RI) == 0;
    if (mon.clear) m_ov = 0;
    if (cap) begin
      if (m_rv && !mon.report_ready) m_ov = 1;
      m_rv = 1; m_rc = CNTW'(m_edges); m_ri = pre; m_win = pre - m_prev; m_prev = pre;
    end else if (m_rv && mon.report_ready) begin
      m_rv = 0;
    end
    if (!mon.commit_is_walk) m_instr = m_instr + CNTW'($countones(mon.commit_valid));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stuck",          64'(mon.stuck),          64'(m_stuck));
    chk("stuck_pulse",    64'(mon.stuck_pulse),    64'(m_pulse));
    chk("report_valid",   64'(mon.report_valid),   64'(m_rv));
    chk("report_cycles",  64'(mon.report_cycles),  64'(m_rc));
    chk("report_instrs",  64'(mon.report_instrs),  64'(m_ri));
    chk("report_overrun", 64'(mon.report_overrun), 64'(m_ov));
`ifdef COMMIT_MONITOR_WINDOW_EN
    chk("report_window",  64'(mon.report_window),  64'(m_win));
`endif
  endtask

  task automatic drive(input logic [CW-1:0] cv, input logic walk, input logic clr, input logic rdy);
    mon.commit_valid   = cv;
    mon.commit_is_walk = walk;
    mon.clear          = clr;
    mon.report_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    drive('0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;

    // Stall detection: one commit, then LIM+1 idle cycles.
    drive(6'b000001, 1'b0, 1'b0, 1'b1); step();
    drive('0, 1'b0, 1'b0, 1'b1);
    repeat (LIM) step();
    chk("stuck_before_limit", 64'(mon.stuck), 64'd0);
    step();
    chk("stuck_rise", 64'(mon.stuck), 64'd1);
    chk("pulse_rise", 64'(mon.stuck_pulse), 64'd1);
    step();
    chk("pulse_one_cycle", 64'(mon.stuck_pulse), 64'd0);
    drive(6'b111111, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("stuck_sticky", 64'(mon.stuck), 64'd1);
    drive('0, 1'b0, 1'b1, 1'b1); step();
    chk("stuck_cleared", 64'(mon.stuck), 64'd0);

    // A walk cycle with lane 0 valid still counts as commit-free.
    drive('0, 1'b0, 1'b0, 1'b1);
    repeat (LIM) step();
    drive(6'b111111, 1'b1, 1'b0, 1'b1); step();
    chk("walk_not_commit", 64'(mon.stuck), 64'd1);
    drive('0, 1'b0, 1'b1, 1'b1); step();

    // Popcount with a walk in the middle, then periodic reports with ready high.
    do_reset();
    drive(6'b101011, 1'b0, 1'b0, 1'b1); step();
    drive(6'b101011, 1'b1, 1'b0, 1'b1); step();
    drive(6'b101011, 1'b0, 1'b0, 1'b1); step();
    drive('0, 1'b0, 1'b0, 1'b1);
    repeat (RI - 3) step();
    chk("first_report_valid", 64'(mon.report_valid), 64'd1);
    chk("first_report_cycles", 64'(mon.report_cycles), 64'd8);
    chk("popcount_walk_instrs", 64'(mon.report_instrs), 64'd8);
    step();
    chk("report_valid_drop", 64'(mon.report_valid), 64'd0);
    repeat (RI - 1) step();
    chk("second_report_cycles", 64'(mon.report_cycles), 64'd16);
    repeat (RI) step();
    chk("third_report_cycles", 64'(mon.report_cycles), 64'd24);
    chk("no_overrun", 64'(mon.report_overrun), 64'd0);

    // Consumer stalled for 20 cycles: second capture overwrites and flags overrun.
    do_reset();
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (2 * RI) step();
    chk("overwrite_cycles", 64'(mon.report_cycles), 64'd16);
    chk("overrun_set", 64'(mon.report_overrun), 64'd1);
    repeat (20 - 2 * RI) step();
    chk("held_valid", 64'(mon.report_valid), 64'd1);
    drive('0, 1'b0, 1'b1, 1'b0); step();
    chk("overrun_cleared", 64'(mon.report_overrun), 64'd0);

    // Random traffic with alternating dense/sparse commit phases.
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      bit dense;
      dense = ($urandom_range(0, 1) == 1);
      for (int n = 0; n < 250; n++) begin
        logic [CW-1:0] cv;
        cv = CW'($urandom);
        if (!dense && $urandom_range(0, 15) != 0) cv = '0;
        drive(cv, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1);
        step();
      end
    end

    // Asynchronous reset while STUCK with a pending report.
    do_reset();
    drive(6'b000001, 1'b0, 1'b0, 1'b0); step();
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (RI - 1) step();
    chk("pre_reset_stuck", 64'(mon.stuck), 64'd1);
    chk("pre_reset_valid", 64'(mon.report_valid), 64'd1);
    reset = 1'b0;
    #2;
    chk("async_stuck", 64'(mon.stuck), 64'd0);
    chk("async_valid", 64'(mon.report_valid), 64'd0);
    chk("async_cycles", 64'(mon.report_cycles), 64'd0);
    chk("async_instrs", 64'(mon.report_instrs), 64'd0);
    model_reset();
    check_all();
    reset = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b1);
    repeat (10 * LIM) step();
    chk("idle_after_reset", 64'(mon.stuck), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
